// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage in front of mem_ctrl. Owns the fetch PC, keeps
//   one request outstanding at a time, captures the single-cycle return and
//   buffers {pc, inst} pairs in a small circular FIFO that feeds IF/ID.
//   A branch redirect flushes the FIFO and retargets fetch; a redirect that
//   lands while a fetch is in flight turns that fetch stale (DROP) so its
//   data is thrown away when it finally returns.
//
// Handshake (IF -> ID): an entry moves when if_valid_o & id_ready_i are both
//   high in the same cycle. if_valid_o never depends on id_ready_i. While
//   rdy_in is low the queue is frozen and if_valid_o is held low.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy_in          global ready; low pauses and aborts any in-flight access
//   fetch_req_o     request outstanding at pc_o (WAIT state)
//   pc_o            address to mem_ctrl, stable from issue until return
//   inst_ok_i/inst_i one-cycle return strobe and instruction data
//   redirect_i/redirect_pc_i  taken branch; target word-aligned internally
//   if_valid_o/if_pc_o/if_inst_o  queue head towards ID
//   id_ready_i      ID accepts the head this cycle
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  output logic        fetch_req_o,
  output logic [31:0] pc_o,
  input  logic        inst_ok_i,
  input  logic [31:0] inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] req_pc, req_pc_nx;

  logic          push, pop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after_pop;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];

  // Queue head towards ID
  assign if_valid_o = (count != '0) & rdy_in;
  assign if_pc_o    = (count != '0) ? pc_mem[rd_ptr]   : 32'h0;
  assign if_inst_o  = (count != '0) ? inst_mem[rd_ptr] : 32'h0;

  // A redirect flushes the queue, so a coincident pop is meaningless.
  assign pop             = if_valid_o & id_ready_i & ~redirect_i;
  assign count_after_pop = count - CW'(pop);

  assign fetch_req_o = (state == WAIT);
  assign pc_o        = req_pc;

  // Next-state / datapath control
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_pc_nx   = req_pc;
    push        = 1'b0;

    case (state)
      IDLE: begin
        // Issue only when a slot is guaranteed for the return: the
        // outstanding fetch reserves one entry, so the push can never
        // meet a full queue.
        if (rdy_in && !redirect_i && (count_after_pop < CW'(FIFO_DEPTH))) begin
          req_pc_nx = fetch_pc;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        if (!rdy_in) begin
          // mem_ctrl aborted the access; fetch_pc is untouched so the
          // same address is requested again once ready returns.
          state_nx = IDLE;
        end else if (redirect_i) begin
          // Data returning this very cycle is simply discarded; otherwise
          // the return is still owed and must be swallowed later.
          state_nx = inst_ok_i ? IDLE : DROP;
        end else if (inst_ok_i) begin
          push        = 1'b1;
          fetch_pc_nx = req_pc + 32'd4;
          state_nx    = IDLE;
        end
      end
      DROP: begin
        // pc_o stays on the stale address: mem_ctrl fills its cache from
        // pc_o at return time.
        if (!rdy_in || inst_ok_i) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (redirect_i) begin
      fetch_pc_nx = redirect_pc_i & ~32'h3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_pc   <= req_pc_nx;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == CW'(FIFO_DEPTH)) && !pop));
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        rdy_in;
  logic        fetch_req_o;
  logic [31:0] pc_o;
  logic        inst_ok_i;
  logic [31:0] inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .fetch_req_o(fetch_req_o), .pc_o(pc_o),
    .inst_ok_i(inst_ok_i), .inst_i(inst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .id_ready_i(id_ready_i)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // One outstanding fetch (busy), possibly made stale by a redirect, and
  // the instruction queue as a plain queue of {pc, inst}.
  logic [63:0] m_q[$];
  logic        m_busy;
  logic        m_stale;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  int          m_age;

  // memory responder settings
  int          mem_lat;
  logic        stray_ok;
  logic [31:0] ilog[$];
  logic [31:0] exp_q[$];

  task automatic model_step();
    logic pop_now;
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0; m_stale = 1'b0;
      m_fetch_pc = RST_PC; m_req_pc = RST_PC;
      return;
    end
    pop_now = (m_q.size() != 0) && rdy_in && id_ready_i && !redirect_i;
    if (redirect_i) m_q.delete();
    else if (pop_now) void'(m_q.pop_front());
    if (!m_busy) begin
      if (rdy_in && !redirect_i && m_q.size() < DEPTH) begin
        m_busy = 1'b1; m_stale = 1'b0; m_req_pc = m_fetch_pc; m_age = 0;
      end
    end else if (!rdy_in) begin
      m_busy = 1'b0;
    end else if (m_stale) begin
      if (inst_ok_i) m_busy = 1'b0;
    end else if (inst_ok_i) begin
      m_busy = 1'b0;
      if (!redirect_i) begin
        m_q.push_back({m_req_pc, inst_i});
        m_fetch_pc = m_req_pc + 32'd4;
      end
    end else if (redirect_i) begin
      m_stale = 1'b1;
    end
    if (redirect_i) m_fetch_pc = redirect_pc_i & ~32'h3;
  endtask

  function automatic logic [97:0] exp_vec();
    logic [63:0] head;
    logic        v;
    head = (m_q.size() != 0) ? m_q[0] : 64'h0;
    v    = (m_q.size() != 0) && rdy_in;
    return {m_busy && !m_stale, m_req_pc, v, head};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {fetch_req_o, pc_o, if_valid_o, if_pc_o, if_inst_o};
  endfunction

  // ---------------- driver tasks ----------------
  // mem_ctrl stand-in: returns mem_lat cycles into each outstanding fetch.
  task automatic mem_drive();
    inst_ok_i = 1'b0;
    inst_i    = $urandom;
    if (m_busy) begin
      m_age++;
      if (m_age == mem_lat) begin
        inst_ok_i = 1'b1;
        ilog.push_back(inst_i);
      end
    end else if (stray_ok) begin
      inst_ok_i = 1'b1;
    end
  endtask

  // Inputs are set at the falling edge; returns at the next falling edge.
  task automatic cyc();
    mem_drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    rdy_in = 1'b1; id_ready_i = 1'b0; stray_ok = 1'b0; mem_lat = 3;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    cyc();
    total++; if (fetch_req_o !== 1'b0) begin bad++; $display("FAIL reset_fetch_req got=%b want=0", fetch_req_o); end
    total++; if (pc_o !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc_o, RST_PC); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if_valid_o); end
    total++; if (if_pc_o !== 32'h0) begin bad++; $display("FAIL reset_if_pc got=%h want=0", if_pc_o); end
    total++; if (if_inst_o !== 32'h0) begin bad++; $display("FAIL reset_if_inst got=%h want=0", if_inst_o); end
    rst = 1'b0;
  endtask

  task automatic test_in_order();
    int first_valid;
    logic [31:0] want_inst;
    apply_reset();
    ilog.delete(); exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    id_ready_i = 1'b1; mem_lat = 3; first_valid = -1;
    for (int k = 1; k <= 40 && exp_q.size() != 0; k++) begin
      if (if_valid_o && id_ready_i) begin
        want_inst = (ilog.size() != 0) ? ilog.pop_front() : 32'hx;
        total++; if (if_pc_o !== exp_q[0]) begin bad++; $display("FAIL order_pc got=%h want=%h", if_pc_o, exp_q[0]); end
        total++; if (if_inst_o !== want_inst) begin bad++; $display("FAIL order_inst got=%h want=%h", if_inst_o, want_inst); end
        void'(exp_q.pop_front());
      end
      cyc();
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL order_vec k=%0d got=%h want=%h", k, dut_vec(), exp_vec()); end
      if (first_valid < 0 && if_valid_o) first_valid = k;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL order_timeout got=%0d left want=0", exp_q.size()); end
    total++; if (first_valid != 4) begin bad++; $display("FAIL first_valid got=%0d want=4", first_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    id_ready_i = 1'b0; mem_lat = 2;
    for (int k = 0; k < 14; k++) begin
      cyc();
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL bp_vec k=%0d got=%h want=%h", k, dut_vec(), exp_vec()); end
    end
    total++; if (fetch_req_o !== 1'b0) begin bad++; $display("FAIL bp_full_req got=%b want=0", fetch_req_o); end
    total++; if (if_pc_o !== 32'h0) begin bad++; $display("FAIL bp_head got=%h want=0", if_pc_o); end
    id_ready_i = 1'b1;
    cyc();
    id_ready_i = 1'b0;
    total++; if (fetch_req_o !== 1'b1 || pc_o !== 32'h8) begin bad++; $display("FAIL bp_refetch got=%b/%h want=1/00000008", fetch_req_o, pc_o); end
    total++; if (if_pc_o !== 32'h4) begin bad++; $display("FAIL bp_head2 got=%h want=4", if_pc_o); end
  endtask

  task automatic test_redirect_wait();
    int k;
    apply_reset();
    id_ready_i = 1'b0; mem_lat = 3;
    k = 0;
    while (!(m_busy && m_req_pc == 32'h4) && k < 20) begin cyc(); k++; end
    total++; if (pc_o !== 32'h4 || fetch_req_o !== 1'b1) begin bad++; $display("FAIL rw_setup got=%b/%h want=1/00000004", fetch_req_o, pc_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h1002;
    cyc();
    redirect_i = 1'b0;
    total++; if (fetch_req_o !== 1'b0 || pc_o !== 32'h4) begin bad++; $display("FAIL rw_drop got=%b/%h want=0/00000004", fetch_req_o, pc_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rw_flush got=%b want=0", if_valid_o); end
    k = 0;
    while (fetch_req_o !== 1'b1 && k < 20) begin
      cyc(); k++;
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rw_vec k=%0d got=%h want=%h", k, dut_vec(), exp_vec()); end
    end
    total++; if (pc_o !== 32'h1000 || fetch_req_o !== 1'b1) begin bad++; $display("FAIL rw_target got=%b/%h want=1/00001000", fetch_req_o, pc_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rw_empty got=%b want=0", if_valid_o); end
  endtask

  task automatic test_redirect_coincident();
    int k;
    apply_reset();
    id_ready_i = 1'b0; mem_lat = 2;
    k = 0;
    while (!(m_busy && m_req_pc == 32'h4 && m_age == mem_lat - 1) && k < 20) begin cyc(); k++; end
    total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL rc_setup got=%b want=1", if_valid_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h2000; id_ready_i = 1'b1;
    cyc();
    redirect_i = 1'b0; id_ready_i = 1'b0;
    total++; if (if_valid_o !== 1'b0 || fetch_req_o !== 1'b0) begin bad++; $display("FAIL rc_flush got=%b/%b want=0/0", if_valid_o, fetch_req_o); end
    cyc();
    total++; if (fetch_req_o !== 1'b1 || pc_o !== 32'h2000) begin bad++; $display("FAIL rc_target got=%b/%h want=1/00002000", fetch_req_o, pc_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rc_empty got=%b want=0", if_valid_o); end
  endtask

  task automatic test_pause();
    int k, n4;
    apply_reset();
    id_ready_i = 1'b1; mem_lat = 3;
    k = 0;
    while (!(m_busy && m_req_pc == 32'h4 && m_age == 1) && k < 20) begin cyc(); k++; end
    rdy_in = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cyc();
      total++; if (fetch_req_o !== 1'b0 || if_valid_o !== 1'b0 || pc_o !== 32'h4) begin bad++; $display("FAIL pause j=%0d got=%b/%b/%h want=0/0/00000004", j, fetch_req_o, if_valid_o, pc_o); end
    end
    rdy_in = 1'b1;
    cyc();
    total++; if (fetch_req_o !== 1'b1 || pc_o !== 32'h4) begin bad++; $display("FAIL pause_rereq got=%b/%h want=1/00000004", fetch_req_o, pc_o); end
    n4 = 0;
    for (int j = 0; j < 20; j++) begin
      if (if_valid_o && id_ready_i && if_pc_o == 32'h4) n4++;
      cyc();
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL pause_vec j=%0d got=%h want=%h", j, dut_vec(), exp_vec()); end
    end
    total++; if (n4 != 1) begin bad++; $display("FAIL pause_once got=%0d want=1", n4); end
  endtask

  task automatic test_wrap();
    int k;
    apply_reset();
    id_ready_i = 1'b1; mem_lat = 1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    cyc();
    redirect_i = 1'b0;
    k = 0;
    while (fetch_req_o !== 1'b1 && k < 20) begin cyc(); k++; end
    total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%h want=fffffffc", pc_o); end
    k = 0;
    while (if_valid_o !== 1'b1 && k < 20) begin cyc(); k++; end
    total++; if (if_pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_entry got=%h want=fffffffc", if_pc_o); end
    k = 0;
    while (fetch_req_o !== 1'b1 && k < 20) begin cyc(); k++; end
    total++; if (pc_o !== 32'h0 || fetch_req_o !== 1'b1) begin bad++; $display("FAIL wrap_next got=%b/%h want=1/00000000", fetch_req_o, pc_o); end
  endtask

  task automatic test_reset_midfetch();
    apply_reset();
    id_ready_i = 1'b1; mem_lat = 4;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (fetch_req_o !== 1'b0 || pc_o !== RST_PC) begin bad++; $display("FAIL rmid_reset got=%b/%h want=0/%h", fetch_req_o, pc_o, RST_PC); end
    stray_ok = 1'b1;
    cyc();
    stray_ok = 1'b0;
    total++; if (if_valid_o !== 1'b0 || fetch_req_o !== 1'b1) begin bad++; $display("FAIL rmid_stray got=%b/%b want=0/1", if_valid_o, fetch_req_o); end
    for (int j = 0; j < 15; j++) begin
      cyc();
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rmid_vec j=%0d got=%h want=%h", j, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int j = 0; j < 600; j++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      redirect_i    = ($urandom_range(0, 11) == 0);
      redirect_pc_i = $urandom;
      id_ready_i    = $urandom_range(0, 1);
      stray_ok      = ($urandom_range(0, 7) == 0);
      if (!m_busy) mem_lat = $urandom_range(1, 4);
      cyc();
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rand_vec j=%0d got=%h want=%h", j, dut_vec(), exp_vec()); end
    end
    redirect_i = 1'b0; stray_ok = 1'b0; rdy_in = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; rdy_in = 1'b1; inst_ok_i = 1'b0; inst_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b0;
    stray_ok = 1'b0; mem_lat = 3;
    m_busy = 1'b0; m_stale = 1'b0; m_fetch_pc = RST_PC; m_req_pc = RST_PC; m_age = 0;
    @(negedge clk);
    test_reset();
    test_in_order();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_pause();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
